// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the serial prefix subtractor.
//   DIG_W        digit width handled per clock
//   stateT       serial FSM states
//   sign_ovf_sub signed-overflow rule for a subtraction, from the three sign bits
package alu_pkg;
    localparam int DIG_W = 4;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;
    function automatic logic sign_ovf_sub(input logic sa, input logic sb, input logic sd);
        return (sa != sb) && (sd != sa);
    endfunction
endpackage

// File: rtl/prefix_sub4.sv
// prefix_sub4: combinational 4-bit Kogge-Stone subtractor, d = x - y - bIn.
//   x, y  in  digit operands (minuend, subtrahend)
//   bIn   in  borrow-in
//   d     out difference digit
//   bOut  out borrow-out
module prefix_sub4
    import alu_pkg::*;
(
    input  logic [DIG_W-1:0] x,
    input  logic [DIG_W-1:0] y,
    input  logic             bIn,
    output logic [DIG_W-1:0] d,
    output logic             bOut
);
    logic [DIG_W-1:0] g, p, g1, g2;
    // Subtraction done as x + ~y + ~bIn; bit 0 folds the inverted borrow into its generate
    always_comb begin
        p = ~(x ^ y);
        g = x & ~y;
        g[0] = (x[0] & ~y[0]) | (~bIn & (x[0] | ~y[0]));
        g1 = g;
        for (int i = 1; i < DIG_W; i++) g1[i] = g[i] | (p[i] & g[i-1]);
        g2 = g1;
        for (int i = 2; i < DIG_W; i++) g2[i] = g1[i] | (p[i] & p[i-1] & g1[i-2]);
        d = p ^ {g2[DIG_W-2:0], ~bIn};
        bOut = ~g2[DIG_W-1];
    end
endmodule

// File: rtl/prefix_sub_serial.sv
// prefix_sub_serial: digit-serial a - b - bIn, one 4-bit digit per clock, valid/ready on both sides.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (a, b, bIn)
//   out_valid, out_ready result handshake (diff, bOut, ovf, zero)
//   diff                 a - b - bIn mod 2^WIDTH (only meaningful while out_valid)
//   bOut                 unsigned borrow-out
//   ovf                  signed overflow
//   zero                 diff == 0
module prefix_sub_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bOut,
    output logic             ovf,
    output logic             zero
);
    localparam int NDIG = WIDTH / DIG_W;
    localparam int CW = $clog2(NDIG);

    if (WIDTH % DIG_W != 0 || WIDTH < 8) begin : gBadWidth
        $error("prefix_sub_serial: WIDTH must be a multiple of 4 and >= 8");
    end

    stateT            state, stateNext;
    logic [WIDTH-1:0] aReg, bReg, diffNext;
    logic [CW-1:0]    cnt;
    logic             borrow, digBorrow, lastDig;
    logic [DIG_W-1:0] dig;

    assign lastDig   = cnt == CW'(NDIG - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    prefix_sub4 uSub (
        .x   (aReg[cnt*DIG_W +: DIG_W]),
        .y   (bReg[cnt*DIG_W +: DIG_W]),
        .bIn (borrow),
        .d   (dig),
        .bOut(digBorrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = (state == IDLE && in_valid)  ? BUSY :
                    (state == BUSY && lastDig)   ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
        diffNext = diff;
        diffNext[cnt*DIG_W +: DIG_W] = dig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aReg   <= '0;
            bReg   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bOut   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else if (in_ready && in_valid) begin
            aReg   <= a;
            bReg   <= b;
            borrow <= bIn;
            cnt    <= '0;
        end else if (state == BUSY) begin
            diff   <= diffNext;
            borrow <= digBorrow;
            cnt    <= cnt + 1'b1;
            if (lastDig) begin
                bOut <= digBorrow;
                ovf  <= sign_ovf_sub(aReg[WIDTH-1], bReg[WIDTH-1], dig[DIG_W-1]);
                zero <= diffNext == '0;
            end
        end
    end
endmodule
